// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, keyboard command bytes
// and the host-to-device frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERROR
    } tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // {stop, odd parity, data}, shifted out LSB first.
    function automatic logic [9:0] tx_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for a raw PS/2 pin plus falling-edge strobe.
// Flops reset high so an idle bus never produces a spurious edge.
module ps2_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic pin_in,
    output logic sync_out,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pin_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out
// one byte on device clocks, then check the device ack bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES        = 1200,
    parameter int unsigned START_TIMEOUT_CYCLES  = 150000,
    parameter int unsigned PACKET_TIMEOUT_CYCLES = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       err_timeout
);

    localparam int unsigned MAX_TO =
        (START_TIMEOUT_CYCLES > PACKET_TIMEOUT_CYCLES) ?
        START_TIMEOUT_CYCLES : PACKET_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYC =
        (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] STA_LAST = CW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PKT_LAST = CW'(PACKET_TIMEOUT_CYCLES - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          data_low_q, data_low_d;
    logic          err_q, err_d;

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    ps2_edge_sync u_clk_sync (
        .clock    (clock),
        .reset    (reset),
        .pin_in   (ps2_clk_in),
        .sync_out (clk_sync),
        .fall     (clk_fall)
    );

    ps2_edge_sync u_data_sync (
        .clock    (clock),
        .reset    (reset),
        .pin_in   (ps2_data_in),
        .sync_out (data_sync),
        .fall     (data_fall_unused)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        data_low_d = data_low_q;
        err_d      = err_q;

        ps2_clk_drive_low  = 1'b0;
        ps2_data_drive_low = 1'b0;
        busy               = 1'b1;
        tx_done            = 1'b0;
        tx_error           = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy       = 1'b0;
                cnt_d      = '0;
                data_low_d = 1'b0;
                if (tx_start) begin
                    shreg_d = tx_frame(tx_data);
                    err_d   = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_drive_low = 1'b1;
                if (cnt_q == INH_LAST) begin
                    // start bit goes out while the clock is still held
                    ps2_data_drive_low = 1'b1;
                    data_low_d         = 1'b1;
                    cnt_d              = '0;
                    state_d            = REQ;
                end
            end
            REQ: begin
                ps2_data_drive_low = data_low_q;
                if (clk_fall) begin
                    data_low_d = ~shreg_q[0];
                    bitcnt_d   = 4'd1;
                    cnt_d      = '0;
                    state_d    = SEND;
                end else if (cnt_q == STA_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end
            SEND: begin
                ps2_data_drive_low = data_low_q;
                if (cnt_q == PKT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (clk_fall) begin
                    data_low_d = ~shreg_q[bitcnt_q];
                    bitcnt_d   = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                ps2_data_drive_low = data_low_q;
                if (cnt_q == PKT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (clk_fall) begin
                    state_d = data_sync ? ERROR : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                ps2_data_drive_low = data_low_q;
                if (cnt_q == PKT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (clk_sync && data_sync) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b0;
                tx_done = 1'b1;
                state_d = IDLE;
            end
            ERROR: begin
                busy       = 1'b0;
                tx_error   = 1'b1;
                data_low_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            data_low_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            data_low_q <= data_low_d;
            err_q      <= err_d;
        end
    end

    assign err_timeout = err_q;

endmodule
